// File: rtl/byte_manip_unit_if.sv
// Handshake/operand bundle between the control FSM and byte_manip_unit.
// The control side uses the master modport; the execution unit uses slave.
interface byte_manip_unit_if #(
  parameter int DATA_W = 16
);
  localparam int LANE_W = $clog2(DATA_W / 8);

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] dst_in;
  logic [7:0]        byte_val;
  logic [LANE_W-1:0] lane;
  logic              ready;
  logic              done;
  logic              ack;
  logic [DATA_W-1:0] dst_out;
  logic              n_flag;
  logic              z_flag;
  logic              err;

  modport master (
    output start, op, dst_in, byte_val, lane, ack,
    input  ready, done, dst_out, n_flag, z_flag, err
  );

  modport slave (
    input  start, op, dst_in, byte_val, lane, ack,
    output ready, done, dst_out, n_flag, z_flag, err
  );
endinterface

// File: rtl/byte_manip_unit.sv
// Handshaked byte-manipulation unit: IDLE -> EXEC -> DONE, result held until ack.
// Optional macro BYTE_MANIP_SXT_EN enables op 5 (SXT); otherwise op 5 is illegal.
module byte_manip_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  byte_manip_unit_if.slave  bus
);
  localparam int LANE_W = $clog2(DATA_W / 8);
  localparam int NB     = DATA_W / 8;

  localparam logic [2:0] OP_MOVL  = 3'd0;
  localparam logic [2:0] OP_MOVLZ = 3'd1;
  localparam logic [2:0] OP_MOVLS = 3'd2;
  localparam logic [2:0] OP_MOVH  = 3'd3;
  localparam logic [2:0] OP_SWPB  = 3'd4;
  localparam logic [2:0] OP_SXT   = 3'd5;
  localparam logic [2:0] OP_MOVB  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] l_q;
  logic [7:0]        b_q;
  logic [LANE_W-1:0] lane_q;
  logic [DATA_W-1:0] dst_out_q;
  logic              n_q, z_q, err_q, done_q;
  logic [DATA_W-1:0] res_d;
  logic              err_d;

`ifdef BYTE_MANIP_SXT_EN
  function automatic logic signed [DATA_W-1:0] sign_extend(input logic signed [7:0] v);
    logic signed [DATA_W-1:0] w;
    w = v;
    return w;
  endfunction
`endif

  function automatic logic is_illegal(input logic [2:0] op);
`ifdef BYTE_MANIP_SXT_EN
    return (op == 3'd7);
`else
    return (op == 3'd7) || (op == OP_SXT);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] calc(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] l,
    input logic [7:0]        b,
    input logic [LANE_W-1:0] ln
  );
    logic [DATA_W-1:0] r;
    r = l;
    case (op)
      OP_MOVL:  r[7:0] = b;
      OP_MOVLZ: r = {{(DATA_W-8){1'b0}}, b};
      OP_MOVLS: r = {{(DATA_W-8){1'b1}}, b};
      OP_MOVH:  r[DATA_W-1 -: 8] = b;
      OP_SWPB: begin
        for (int i = 0; i < NB; i++) begin
          r[i*8 +: 8] = l[(NB-1-i)*8 +: 8];
        end
      end
`ifdef BYTE_MANIP_SXT_EN
      OP_SXT:   r = sign_extend(l[7:0]);
`endif
      OP_MOVB:  r[int'(ln)*8 +: 8] = b;
      default:  r = l;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (bus.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_d = calc(op_q, l_q, b_q, lane_q);
    err_d = is_illegal(op_q);
  end

  // Operand capture: only in IDLE on start, so later starts cannot disturb a held result
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      op_q   <= bus.op;
      l_q    <= bus.dst_in;
      b_q    <= bus.byte_val;
      lane_q <= bus.lane;
    end
  end

  // Result stage: dst_out, flags and err change only when leaving EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      dst_out_q <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      if (state_q == EXEC) begin
        dst_out_q <= res_d;
        n_q       <= res_d[DATA_W-1];
        z_q       <= (res_d == '0);
        err_q     <= err_d;
      end
    end
  end

  assign bus.ready   = (state_q == IDLE) && !rst;
  assign bus.done    = done_q;
  assign bus.dst_out = dst_out_q;
  assign bus.n_flag  = n_q;
  assign bus.z_flag  = z_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_byte_manip_unit.sv
// Scoreboard bench for byte_manip_unit at DATA_W=16 and DATA_W=32.
module tb_byte_manip_unit;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_manip_unit_if #(.DATA_W(16)) if16 ();
  byte_manip_unit_if #(.DATA_W(32)) if32 ();

  byte_manip_unit #(.DATA_W(16)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
  byte_manip_unit #(.DATA_W(32)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));

  typedef struct {
    logic [63:0] dst;
    logic        n;
    logic        z;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;
  logic d16_prev = 1'b0;
  logic d32_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Monitors: compare on every rising edge of done
  always @(negedge clk) begin
    if (if16.done === 1'b1 && !d16_prev) begin
      if (q16.size() == 0) begin
        checks++; failures++;
        $display("FAIL u16_unexpected_done actual=1 expected=0");
      end else begin
        e16 = q16.pop_front();
        chk("u16_dst", 64'(if16.dst_out), e16.dst);
        chk("u16_n", 64'(if16.n_flag), 64'(e16.n));
        chk("u16_z", 64'(if16.z_flag), 64'(e16.z));
        chk("u16_err", 64'(if16.err), 64'(e16.e));
        chk("u16_latency", 64'(cyc - e16.cyc), 64'd1);
      end
    end
    d16_prev = (if16.done === 1'b1);
  end

  always @(negedge clk) begin
    if (if32.done === 1'b1 && !d32_prev) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL u32_unexpected_done actual=1 expected=0");
      end else begin
        e32 = q32.pop_front();
        chk("u32_dst", 64'(if32.dst_out), e32.dst);
        chk("u32_n", 64'(if32.n_flag), 64'(e32.n));
        chk("u32_z", 64'(if32.z_flag), 64'(e32.z));
        chk("u32_err", 64'(if32.err), 64'(e32.e));
        chk("u32_latency", 64'(cyc - e32.cyc), 64'd1);
      end
    end
    d32_prev = (if32.done === 1'b1);
  end

  task automatic issue(input bit w, input logic [2:0] op, input logic [63:0] l,
                       input logic [7:0] b, input int ln, input logic [63:0] xd,
                       input logic xn, input logic xz, input logic xe);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!(w ? if32.ready : if16.ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
      return;
    end
    if (w) begin
      if32.op = op; if32.dst_in = l[31:0]; if32.byte_val = b;
      if32.lane = 2'(ln); if32.start = 1'b1;
    end else begin
      if16.op = op; if16.dst_in = l[15:0]; if16.byte_val = b;
      if16.lane = 1'(ln); if16.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if32.start = 1'b0;
    if16.start = 1'b0;
    e.dst = xd; e.n = xn; e.z = xz; e.e = xe; e.cyc = cyc;
    if (w) q32.push_back(e); else q16.push_back(e);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    if16.start = 1'b1; if16.op = 3'd0; if16.dst_in = 16'h1234; if16.byte_val = 8'hAB;
    if16.lane = 1'b0; if16.ack = 1'b1;
    if32.start = 1'b1; if32.op = 3'd0; if32.dst_in = 32'h0; if32.byte_val = 8'h0;
    if32.lane = 2'd0; if32.ack = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(if16.ready), 64'd0);
    chk("rst_dst", 64'(if16.dst_out), 64'h0);
    chk("rst_z", 64'(if16.z_flag), 64'd1);
    chk("rst_n", 64'(if16.n_flag), 64'd0);
    chk("rst_done", 64'(if16.done), 64'd0);
    chk("rst_err", 64'(if16.err), 64'd0);
    if16.start = 1'b0; if32.start = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready16", 64'(if16.ready), 64'd1);
    chk("post_rst_ready32", 64'(if32.ready), 64'd1);

    // 16-bit lane moves
    issue(0, 3'd0, 64'h1234, 8'hAB, 0, 64'h12AB, 1'b0, 1'b0, 1'b0);
    issue(0, 3'd1, 64'h1234, 8'hAB, 0, 64'h00AB, 1'b0, 1'b0, 1'b0);
    issue(0, 3'd2, 64'h1234, 8'hAB, 0, 64'hFFAB, 1'b1, 1'b0, 1'b0);
    issue(0, 3'd3, 64'h1234, 8'hAB, 0, 64'hAB34, 1'b1, 1'b0, 1'b0);
    issue(0, 3'd1, 64'hFFFF, 8'h00, 0, 64'h0000, 1'b0, 1'b1, 1'b0);
    issue(0, 3'd6, 64'h1234, 8'hAB, 1, 64'hAB34, 1'b1, 1'b0, 1'b0);
    issue(0, 3'd7, 64'h1234, 8'hAB, 0, 64'h1234, 1'b0, 1'b0, 1'b1);
`ifdef BYTE_MANIP_SXT_EN
    issue(0, 3'd5, 64'h0080, 8'h55, 0, 64'hFF80, 1'b1, 1'b0, 1'b0);
    issue(0, 3'd5, 64'h0000, 8'h55, 0, 64'h0000, 1'b0, 1'b1, 1'b0);
`else
    issue(0, 3'd5, 64'h0080, 8'h55, 0, 64'h0080, 1'b0, 1'b0, 1'b1);
`endif

    // 32-bit swap / lane select
    issue(1, 3'd4, 64'h11223344, 8'h00, 0, 64'h44332211, 1'b0, 1'b0, 1'b0);
    issue(1, 3'd6, 64'h11223344, 8'hEE, 2, 64'h11EE3344, 1'b0, 1'b0, 1'b0);
    issue(1, 3'd6, 64'h11223344, 8'hEE, 3, 64'hEE223344, 1'b1, 1'b0, 1'b0);
    issue(1, 3'd3, 64'h11223344, 8'hAB, 0, 64'hAB223344, 1'b1, 1'b0, 1'b0);
    issue(1, 3'd7, 64'h80000000, 8'h12, 0, 64'h80000000, 1'b1, 1'b0, 1'b1);

    // Hold result with ack low; a start during DONE must be dropped
    if16.ack = 1'b0;
    issue(0, 3'd0, 64'h5678, 8'hCD, 0, 64'h56CD, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (if16.done !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) begin
      checks++; failures++;
      $display("FAIL hs_done_timeout actual=0 expected=1");
    end
    for (int i = 0; i < 5; i++) begin
      chk("hs_done", 64'(if16.done), 64'd1);
      chk("hs_dst", 64'(if16.dst_out), 64'h56CD);
      chk("hs_ready", 64'(if16.ready), 64'd0);
      if (i == 1) begin
        if16.op = 3'd1; if16.dst_in = 16'hFFFF; if16.byte_val = 8'h00; if16.start = 1'b1;
      end else begin
        if16.start = 1'b0;
      end
      @(negedge clk);
    end
    if16.start = 1'b0;
    if16.ack = 1'b1;
    @(negedge clk);
    chk("hs_ack_ready", 64'(if16.ready), 64'd1);
    chk("hs_ack_done", 64'(if16.done), 64'd0);
    chk("hs_idle_hold", 64'(if16.dst_out), 64'h56CD);
    issue(0, 3'd4, 64'h1234, 8'h00, 0, 64'h3412, 1'b0, 1'b0, 1'b0);

    // Reset during EXEC: result discarded, done never rises
    t = 0;
    @(negedge clk);
    while (!if16.ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if16.op = 3'd0; if16.dst_in = 16'h1234; if16.byte_val = 8'h11; if16.start = 1'b1;
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_dst", 64'(if16.dst_out), 64'h0);
    chk("midrst_z", 64'(if16.z_flag), 64'd1);
    chk("midrst_done", 64'(if16.done), 64'd0);
    chk("midrst_ready", 64'(if16.ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 64'(if16.ready), 64'd1);
    repeat (5) @(negedge clk);
    issue(0, 3'd2, 64'h0000, 8'h01, 0, 64'hFF01, 1'b1, 1'b0, 1'b0);

    t = 0;
    while ((q16.size() != 0 || q32.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q16.size() != 0 || q32.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", q16.size() + q32.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_manip_unit.md
# byte_manip_unit

Parametrised, handshaked byte-manipulation execution unit for the CPU datapath; successor to the single-strobe 16-bit byte manipulator. It accepts an operation, a destination word and an immediate byte, then produces a registered result and N/Z flags after a fixed two-edge latency. The result is held until the control unit acknowledges it. It sits between the decode/control FSM and register-file write-back, and supports any word width of 16, 32 or 64 bits.

## Interface
- DATA_W, 16, datapath width; legal values 16, 32, 64
- LANE_W, $clog2(DATA_W/8), byte-lane index width (derived; do not override)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; accepted only when ready=1
- op  input  3  operation code, sampled with start
- dst_in  input  DATA_W  destination operand, sampled with start
- byte_val  input  8  immediate byte, sampled with start
- lane  input  LANE_W  target lane for MOVB, sampled with start
- ready  output  1  unit idle, can accept start
- done  output  1  result valid; held until ack
- ack  input  1  consumer accepts result
- dst_out  output  DATA_W  result word
- n_flag  output  1  dst_out[DATA_W-1]
- z_flag  output  1  dst_out == 0
- err  output  1  illegal op on the held result

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE: ready=1. If start=1, latch op/dst_in/byte_val/lane and go to EXEC. Otherwise stay in IDLE.
- EXEC: compute the result into the dst_out register, update flags and err, then go to DONE. ready=0.
- DONE: done=1 and ready=0. Outputs are frozen. If ack=1, go to IDLE; otherwise stay in DONE.
- Op codes (L = latched dst_in, B = latched byte_val):
  - 0 MOVL: lane 0 = B; other lanes = L.
  - 1 MOVLZ: lane 0 = B; other lanes = 0x00.
  - 2 MOVLS: lane 0 = B; other lanes = 0xFF.
  - 3 MOVH: top lane (DATA_W/8-1) = B; other lanes = L.
  - 4 SWPB: reverse byte order of L. At 16 bits this is a high/low swap.
  - 5 SXT: sign-extend L[7:0] to DATA_W. B is ignored. Exists only with the macro.
  - 6 MOVB: lane `lane` = B; other lanes = L.
  - 7, and 5 when SXT is compiled out: illegal. dst_out = L and err=1.
- Flags and err are written only in EXEC, together with dst_out.
- start while ready=0 is ignored; no queuing.
- ack outside DONE is ignored.
- start=1 in the same cycle the FSM returns to IDLE is not accepted; it is accepted only on the next IDLE cycle.

## Timing
- Sequence: start sampled at edge k → EXEC during cycle k+1 → result latched at edge k+1 → done=1 from edge k+1.
- Latency: two edges from start to done. Minimum throughput: one op every 3 cycles (ack held high).
- ready = (state==IDLE) and not rst. ready is combinational from the state.
- done = (state==DONE), registered.
- Reset values: state IDLE, dst_out 0, n_flag 0, z_flag 1, err 0, done 0. ready is 0 while rst=1 and 1 after rst deasserts.
- rst mid-operation (EXEC or DONE): abort and return to IDLE at the next edge. The result is discarded, and all outputs take their reset values.
- rst has priority over start and ack in the same cycle.
- dst_out, flags and err hold their last value in IDLE until the next EXEC.

## Configuration
- BYTE_MANIP_SXT_EN defined: op 5 is SXT as described above.
- BYTE_MANIP_SXT_EN undefined: op 5 is illegal. dst_out = L, err=1, and no sign-extension logic is instantiated.

## Test plan
- Reset: DATA_W=16, hold rst for 2 cycles with start=1 → dst_out=0x0000, z_flag=1, done=0, ready=0 during reset and ready=1 after.
- MOVL/MOVLZ/MOVLS/MOVH: DATA_W=16, L=0x1234, B=0xAB → respectively 0x12AB, 0x00AB (n=0), 0xFFAB (n=1), 0xAB34. Each has done exactly 2 edges after start and err=0.
- SWPB/MOVB at DATA_W=32: SWPB on L=0x11223344 → 0x44332211. MOVB with lane=2, B=0xEE, L=0x11223344 → 0x11EE3344.
- SXT (macro defined): L=0x0080 → 0xFF80, n=1. L=0x0000 → z=1. With the macro undefined, op 5 on L=0x0080 → dst_out=0x0080 and err=1.
- Handshake: hold ack=0 for 5 cycles in DONE → dst_out stable and done=1 throughout. A second start during DONE is ignored. ack=1 → IDLE next edge, and the next start completes normally.
- Reset mid-op: assert rst in the EXEC cycle → IDLE next edge, done never rises, dst_out=0.
